// File: rtl/vecmat_tile_sched.sv
// vecmat_tile_sched
// Runs the 1x16 by 16x10 vector-matrix engine once per K-slice (tile).
// For each tile it:
//   - presents the tile index to the operand buffers,
//   - pulses the engine enable,
//   - waits for the engine to finish (with a timeout),
//   - adds the engine's signed partial sums into wide per-lane accumulators.
// After the last tile it returns the saturated 1xLANES result with a done pulse.
//
// Ports
//   clk         clock, rising edge
//   rst         asynchronous reset, active low
//   start       job request, accepted only in IDLE
//   abort       synchronous cancel of a running job
//   busy        high in every non-IDLE state
//   done        one-cycle pulse while result is valid
//   err         set on engine timeout, cleared by the next accepted start
//   tile_idx    K-slice selector for the operand buffers
//   eng_en      one-cycle engine enable
//   eng_clr     one-cycle engine clear (active high)
//   eng_finish  engine completion level
//   eng_psum    engine partial sums, lane 0 in the MSBs
//   result      final vector, lane 0 in the MSBs
//
// state  | meaning
// -------+----------------------------------------------------------------
// IDLE   | waiting for start; result/err hold the last job's outcome
// ISSUE  | engine enable pulse for the current tile, timeout timer loaded
// WAIT   | waiting for eng_finish (ignored in the first cycle), timer runs
// ACCUM  | add captured partial sums, clear engine, advance or finish
// DONE   | result presented with done pulse

module vecmat_tile_sched #(
   parameter int NUM_TILES = 4,
   parameter int LANES     = 10,
   parameter int PSUM_W    = 16,
   parameter int ACC_W     = 20,
   parameter int OUT_W     = 16,
   parameter int TIMEOUT   = 64,
   localparam int TILE_W   = (NUM_TILES > 1) ? $clog2(NUM_TILES) : 1
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      start,
   input  logic                      abort,
   output logic                      busy,
   output logic                      done,
   output logic                      err,
   output logic [TILE_W-1:0]         tile_idx,
   output logic                      eng_en,
   output logic                      eng_clr,
   input  logic                      eng_finish,
   input  logic [LANES*PSUM_W-1:0]   eng_psum,
   output logic [LANES*OUT_W-1:0]    result
);

   localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
   localparam logic [CNT_W-1:0]        CNT_LOAD  = CNT_W'(TIMEOUT - 1);
   localparam logic [TILE_W-1:0]       LAST_TILE = TILE_W'(NUM_TILES - 1);
   localparam logic signed [ACC_W-1:0] SAT_MAX   = ACC_W'((2 ** (OUT_W - 1)) - 1);
   // In two's complement the most negative value is the bitwise inverse of the most positive.
   localparam logic signed [ACC_W-1:0] SAT_MIN   = ~SAT_MAX;

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_ISSUE = 3'd1,
      S_WAIT  = 3'd2,
      S_ACCUM = 3'd3,
      S_DONE  = 3'd4
   } state_t;

   state_t                     state;
   state_t                     state_nxt;
   logic [CNT_W-1:0]           wait_cnt;
   logic [TILE_W-1:0]          tile_idx_q;
   logic                       err_q;
   logic                       clr_q;
   logic [LANES*PSUM_W-1:0]    psum_q;
   logic [LANES*OUT_W-1:0]     result_q;
   logic [LANES*OUT_W-1:0]     sat_vec;
   logic signed [ACC_W-1:0]    acc [LANES];

   logic first_wait;
   logic fin_ok;
   logic tmo_hit;
   logic last_tile;
   logic aborting;

   // The timer is loaded with TIMEOUT-1 in ISSUE, so the loaded value marks the
   // first WAIT cycle (where a finish left over from the previous tile is ignored)
   // and zero marks the TIMEOUT-th WAIT cycle.
   assign first_wait = (wait_cnt == CNT_LOAD);
   assign fin_ok     = eng_finish & ~first_wait;
   assign tmo_hit    = (wait_cnt == '0) & ~fin_ok;
   assign last_tile  = (tile_idx_q == LAST_TILE);
   assign aborting   = abort & (state != S_IDLE);

   function automatic logic signed [ACC_W-1:0] sext_lane(input logic [PSUM_W-1:0] p);
      return {{(ACC_W - PSUM_W){p[PSUM_W-1]}}, p};
   endfunction

   function automatic logic [OUT_W-1:0] sat_lane(input logic signed [ACC_W-1:0] a);
      if (a > SAT_MAX)
         return SAT_MAX[OUT_W-1:0];
      else if (a < SAT_MIN)
         return SAT_MIN[OUT_W-1:0];
      else
         return a[OUT_W-1:0];
   endfunction

   always_comb begin
      sat_vec = '0;
      for (int l = 0; l < LANES; l++)
         sat_vec[(LANES-1-l)*OUT_W +: OUT_W] = sat_lane(acc[l]);
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst)
         state <= S_IDLE;
      else
         state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE:  if (start) state_nxt = S_ISSUE;
         S_ISSUE: state_nxt = S_WAIT;
         S_WAIT: begin
            if (fin_ok)
               state_nxt = S_ACCUM;
            else if (tmo_hit)
               state_nxt = S_DONE;
         end
         S_ACCUM: state_nxt = last_tile ? S_DONE : S_ISSUE;
         S_DONE:  state_nxt = S_IDLE;
         default: state_nxt = S_IDLE;
      endcase
      if (aborting)
         state_nxt = S_IDLE;
   end

   // An abort in ACCUM or DONE leaves exactly one clear pulse (from clr_q) and no done.
   always_comb begin
      busy    = (state != S_IDLE);
      eng_en  = (state == S_ISSUE);
      eng_clr = clr_q | ((state == S_ACCUM) & ~abort);
      done    = (state == S_DONE) & ~abort;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wait_cnt   <= '0;
         tile_idx_q <= '0;
         err_q      <= 1'b0;
         clr_q      <= 1'b0;
         psum_q     <= '0;
         result_q   <= '0;
         for (int l = 0; l < LANES; l++)
            acc[l] <= '0;
      end else begin
         clr_q <= 1'b0;
         if (aborting) begin
            clr_q <= 1'b1;
         end else begin
            case (state)
               S_IDLE: begin
                  if (start) begin
                     tile_idx_q <= '0;
                     err_q      <= 1'b0;
                     for (int l = 0; l < LANES; l++)
                        acc[l] <= '0;
                  end
               end
               S_ISSUE: wait_cnt <= CNT_LOAD;
               S_WAIT: begin
                  if (fin_ok) begin
                     psum_q <= eng_psum;
                  end else if (tmo_hit) begin
                     err_q <= 1'b1;
                     clr_q <= 1'b1;
                  end else begin
                     wait_cnt <= wait_cnt - CNT_W'(1);
                  end
               end
               S_ACCUM: begin
                  for (int l = 0; l < LANES; l++)
                     acc[l] <= acc[l] + sext_lane(psum_q[(LANES-1-l)*PSUM_W +: PSUM_W]);
                  if (!last_tile)
                     tile_idx_q <= tile_idx_q + TILE_W'(1);
               end
               S_DONE: result_q <= err_q ? '0 : sat_vec;
               default: ;
            endcase
         end
      end
   end

   assign tile_idx = tile_idx_q;
   assign err      = err_q;
   // During DONE the fresh value is shown directly so it is valid alongside done;
   // it is latched into result_q on the way out unless the job is aborted.
   assign result   = (state == S_DONE) ? (err_q ? '0 : sat_vec) : result_q;

endmodule

// File: tb/tb_vecmat_tile_sched.sv
module tb_vecmat_tile_sched;

   localparam int NT  = 4;
   localparam int LN  = 10;
   localparam int PW  = 16;
   localparam int OW  = 16;
   localparam int TMO = 64;

   logic              clk = 1'b0;
   logic              rst_n;
   logic              start;
   logic              abort;
   logic              busy;
   logic              done;
   logic              err;
   logic [1:0]        tile_idx;
   logic              eng_en;
   logic              eng_clr;
   logic              eng_finish;
   logic [LN*PW-1:0]  eng_psum;
   logic [LN*OW-1:0]  result;

   vecmat_tile_sched dut (
      .clk        (clk),
      .rst        (rst_n),
      .start      (start),
      .abort      (abort),
      .busy       (busy),
      .done       (done),
      .err        (err),
      .tile_idx   (tile_idx),
      .eng_en     (eng_en),
      .eng_clr    (eng_clr),
      .eng_finish (eng_finish),
      .eng_psum   (eng_psum),
      .result     (result)
   );

   always #5 clk = ~clk;

   int tests = 0;
   int fails = 0;

   // Engine stand-in: raises finish W cycles after the enable cycle, drops it on clear.
   int  psum_tab [NT][LN];
   int  eng_w     = 3;
   int  hang_tile = -1;
   bit  stale_fin = 1'b0;
   int  e_cnt;
   bit  e_fin;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         e_cnt <= 0;
         e_fin <= 1'b0;
      end else if (eng_clr) begin
         e_cnt <= 0;
         e_fin <= 1'b0;
      end else if (eng_en) begin
         e_cnt <= (hang_tile == int'(tile_idx)) ? 0 : eng_w - 1;
      end else if (e_cnt == 1) begin
         e_fin <= 1'b1;
         e_cnt <= 0;
      end else if (e_cnt > 1) begin
         e_cnt <= e_cnt - 1;
      end
   end

   assign eng_finish = e_fin | stale_fin;

   // Partial sums are only meaningful while the engine reports finish; otherwise a filler pattern.
   always_comb begin
      eng_psum = '0;
      for (int l = 0; l < LN; l++)
         eng_psum[(LN-1-l)*PW +: PW] = e_fin ? PW'(psum_tab[tile_idx][l]) : 16'h5555;
   end

   typedef struct {
      logic [LN*OW-1:0] res;
      logic             e;
   } exp_t;

   exp_t             sb_q[$];
   logic [LN*OW-1:0] last_res = '0;
   logic             last_err = 1'b0;

   task automatic check(input string name, input logic [159:0] act, input logic [159:0] req);
      tests++;
      if (act !== req) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, req, $time);
      end
   endtask

   // Scoreboard monitor: every done pulse consumes one expectation.
   always @(negedge clk) begin
      exp_t e;
      if (rst_n === 1'b1 && done === 1'b1) begin
         if (sb_q.size() == 0) begin
            tests++;
            fails++;
            $display("FAIL unexpected_done: got done=1 expected no done (t=%0t)", $time);
         end else begin
            e = sb_q.pop_front();
            check("result", 160'(result), 160'(e.res));
            check("done_err", 160'(err), 160'(e.e));
         end
      end
   end

   // kind: 0 random, 1 lane k -> k+1, 2 all 0x7000, 3 all 0x9000, 4 mixed per tile
   task automatic run_job(input int kind, input int w, input int hang, input int abort_tile,
                          input int rst_tile, input bit stale, input bit noise);
      logic [LN*OW-1:0] er;
      logic             ee;
      exp_t             ex;
      int               sum, cyc, ntile, clr_cnt, en_cyc, exp_lat, exp_n;
      int               mixed [NT];
      bit               done_seen, stopped;
      mixed = '{100, -300, 50, 25};
      eng_w     = w;
      hang_tile = hang;
      for (int t = 0; t < NT; t++)
         for (int l = 0; l < LN; l++)
            case (kind)
               1:       psum_tab[t][l] = l + 1;
               2:       psum_tab[t][l] = 28672;
               3:       psum_tab[t][l] = -28672;
               4:       psum_tab[t][l] = mixed[t];
               default: psum_tab[t][l] = int'($urandom_range(0, 65535)) - 32768;
            endcase
      er = '0;
      ee = 1'b0;
      for (int l = 0; l < LN; l++) begin
         sum = 0;
         for (int t = 0; t < NT; t++)
            sum += psum_tab[t][l];
         if (sum > 32767)  sum = 32767;
         if (sum < -32768) sum = -32768;
         er[(LN-1-l)*OW +: OW] = OW'(sum);
      end
      if (hang >= 0) begin
         er = '0;
         ee = 1'b1;
      end
      if (abort_tile < 0) begin
         ex.res = er;
         ex.e   = ee;
         sb_q.push_back(ex);
      end

      @(negedge clk);
      start     = 1'b1;
      stale_fin = stale;
      @(negedge clk);
      start = 1'b0;
      cyc = 1; ntile = 0; clr_cnt = 0; en_cyc = -10;
      done_seen = 1'b0; stopped = 1'b0;
      check("err_clear", 160'(err), 160'(0));
      check("busy_issue", 160'(busy), 160'(1));
      while (cyc < 400 && !done_seen && !stopped) begin
         if (eng_en) begin
            check("tile_seq", 160'(tile_idx), 160'(ntile));
            ntile++;
            en_cyc = cyc;
         end
         if (eng_clr) clr_cnt++;
         if (done) begin
            done_seen = 1'b1;
         end else if (abort_tile >= 0 && ntile - 1 == abort_tile && cyc == en_cyc + 1) begin
            abort = 1'b1;
            @(negedge clk);
            abort = 1'b0;
            check("abort_idle", 160'(busy), 160'(0));
            check("abort_clr", 160'(eng_clr), 160'(1));
            @(negedge clk);
            check("abort_clr_once", 160'(eng_clr), 160'(0));
            check("abort_keep_res", 160'(result), 160'(last_res));
            check("abort_keep_err", 160'(err), 160'(last_err));
            stopped = 1'b1;
         end else if (rst_tile >= 0 && ntile - 1 == rst_tile && eng_clr && busy) begin
            #1 rst_n = 1'b0;
            #1;
            check("rst_busy", 160'(busy), 160'(0));
            check("rst_outs", 160'({eng_en, done, err, eng_clr, tile_idx}), 160'(0));
            check("rst_result", 160'(result), 160'(0));
            void'(sb_q.pop_back());
            last_res = '0;
            last_err = 1'b0;
            @(negedge clk);
            rst_n = 1'b1;
            stopped = 1'b1;
         end else begin
            if (stale && cyc == 3) stale_fin = 1'b0;
            start = noise && ($urandom_range(0, 2) == 0);
            @(negedge clk);
            cyc++;
         end
      end
      start     = 1'b0;
      stale_fin = 1'b0;
      if (!stopped) begin
         exp_lat = (hang >= 0) ? hang * (w + 2) + TMO + 2 : NT * (w + 2) + 1;
         exp_n   = (hang >= 0) ? hang + 1 : NT;
         check("done_seen", 160'(done_seen), 160'(1));
         check("latency", 160'(cyc), 160'(exp_lat));
         check("tile_count", 160'(ntile), 160'(exp_n));
         check("clr_count", 160'(clr_cnt), 160'(exp_n));
         last_res = er;
         last_err = ee;
         @(negedge clk);
         check("idle_after", 160'({busy, done}), 160'(0));
         check("held_result", 160'(result), 160'(er));
      end
   endtask

   initial begin
      rst_n = 1'b0;
      start = 1'b0;
      abort = 1'b0;
      #1;
      check("reset_outs", 160'({busy, done, err, eng_en, eng_clr, tile_idx}), 160'(0));
      check("reset_result", 160'(result), 160'(0));
      repeat (2) @(negedge clk);
      rst_n = 1'b1;

      run_job(1, 3, -1, -1, -1, 1'b0, 1'b0);   // basic, latency 21 edges after accept
      run_job(2, 2, -1, -1, -1, 1'b0, 1'b0);   // positive saturation
      run_job(3, 4, -1, -1, -1, 1'b0, 1'b0);   // negative saturation
      run_job(4, 3, -1, -1, -1, 1'b0, 1'b1);   // mixed signs, start noise while busy
      run_job(0, 3,  2, -1, -1, 1'b0, 1'b0);   // timeout on tile 2
      run_job(0, $urandom_range(2, 6), -1, -1, -1, 1'b0, 1'b0);
      run_job(0, 3, -1,  1, -1, 1'b0, 1'b0);   // abort in WAIT of tile 1
      run_job(0, 2, -1, -1, -1, 1'b0, 1'b0);   // immediate restart
      run_job(0, 3, -1, -1, -1, 1'b1, 1'b0);   // stale finish in ISSUE/first WAIT
      run_job(0, 3, -1, -1,  1, 1'b0, 1'b0);   // async reset in ACCUM of tile 1
      for (int j = 0; j < 6; j++)
         run_job(0, $urandom_range(2, 6), -1, -1, -1, 1'b0, 1'b1);

      repeat (3) @(negedge clk);
      check("sb_drain", 160'(sb_q.size()), 160'(0));
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: got no completion expected finish before time limit");
      $fatal(1, "watchdog expired");
   end

endmodule

// File: doc/vecmat_tile_sched.md
Name: vecmat_tile_sched

Overview:
- Sequences the 1x16 by 16x10 vector-matrix engine across NUM_TILES K-slices to compute a 1x(16*NUM_TILES) by (16*NUM_TILES)x10 product (default 1x64 by 64x10).
- Presents tile indices to the operand buffers and issues engine enable/clear pulses.
- Accumulates the engine's 10 signed 16-bit partial sums per tile and returns a saturated 1x10 result with start/done handshake.

Parameters:
- NUM_TILES, 4: K-slices per job (>=1).
- LANES, 10: output columns.
- PSUM_W, 16: engine partial-sum width per lane.
- ACC_W, 20: internal accumulator width per lane (>= PSUM_W + clog2(NUM_TILES)).
- OUT_W, 16: result width per lane.
- TIMEOUT, 64: maximum WAIT cycles per tile before error.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- start  in  1  job request; accepted only in IDLE.
- abort  in  1  synchronous cancel of a running job.
- busy  out  1  high from the cycle after start acceptance until return to IDLE.
- done  out  1  one-cycle pulse when result is valid.
- err  out  1  set on timeout, held until the next accepted start.
- tile_idx  out  clog2(NUM_TILES) (min 1)  K-slice selector for the ai/Matrix buffers.
- eng_en  out  1  one-cycle engine enable pulse.
- eng_clr  out  1  one-cycle engine clear (active-high, matches the engine's reset polarity).
- eng_finish  in  1  engine completion level.
- eng_psum  in  LANES*PSUM_W  engine output; lane 0 in the MSBs [159:144].
- result  out  LANES*OUT_W  final vector, same lane packing; held until the next accepted start.

Behaviour:
- Reset (rst=0, async): state=IDLE; busy, done, err, eng_en, eng_clr, tile_idx, result, accumulators and timeout counter all 0.
- States: IDLE, ISSUE, WAIT, ACCUM, DONE.
- IDLE:
  - start=1 -> clear accumulators, tile_idx=0, err=0, go to ISSUE.
  - start while not IDLE is ignored.
- ISSUE (1 cycle): eng_en=1; timeout counter cleared; go to WAIT. tile_idx is stable from ISSUE through ACCUM of the same tile.
- WAIT:
  - eng_finish is sampled only from the second WAIT cycle on, so a stale finish during eng_en is ignored.
  - On eng_finish=1: capture eng_psum into ACCUM.
  - Else increment the counter. When the counter reaches TIMEOUT: err=1, eng_clr pulse, go to DONE with result=0.
- ACCUM (1 cycle):
  - Each lane acc += sign-extended psum lane, wrap-free by ACC_W sizing.
  - eng_clr=1 to drop engine finish.
  - If tile_idx==NUM_TILES-1 -> DONE; else tile_idx+1 -> ISSUE.
- DONE (1 cycle):
  - Each lane of result = acc saturated to signed OUT_W: >2^(OUT_W-1)-1 gives 0x7FFF; <-2^(OUT_W-1) gives 0x8000.
  - On timeout, result=0 instead.
  - done=1; go to IDLE.
- busy timing: busy=1 in ISSUE/WAIT/ACCUM/DONE, 0 in IDLE. done and busy are both high in the DONE cycle.
- Latency with engine response W cycles after eng_en: start accept + NUM_TILES*(1+W+1) + 1 cycles to the done pulse.
- abort=1 in any non-IDLE state:
  - Next state is IDLE with eng_clr=1 for one cycle.
  - No done; result and err unchanged.
  - abort has priority over eng_finish and timeout in the same cycle.
  - abort in IDLE is ignored; abort and start together in IDLE means start is accepted.
- Reset mid-job: immediate return to IDLE; no done pulse.
- NUM_TILES=1: a single ISSUE/WAIT/ACCUM pass, tile_idx constant 0.

Test Plan:
- Basic job: NUM_TILES=4, engine model returns lane k psum = k+1 per tile after W=3 -> done at cycle 1+4*5+1=22 after start; result lanes = 4,8,...,40; tile_idx sequence 0,1,2,3.
- Signed accumulate/saturation: every tile returns all lanes 0x7000 -> acc 0x1C000, result lanes 0x7FFF; all tiles 0x9000 -> result lanes 0x8000; mixed +100,-300,+50,+25 -> -125 (0xFF83).
- Timeout: engine never raises finish on tile 2 -> err=1 and done after TIMEOUT=64 WAIT cycles, result=0, eng_clr pulsed; next start clears err.
- Abort: abort during WAIT of tile 1 -> IDLE next cycle, eng_clr one pulse, no done, previous result retained; an immediate restart yields a correct result.
- Async reset mid-ACCUM: rst low between clock edges -> busy/eng_en/done drop immediately; all outputs 0.
- Stale finish / start while busy: eng_finish held high during ISSUE is not captured early; start pulses while busy do not restart or alter tile_idx.
